// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one registered request in flight at a time.
// Latency handshake->resp_valid = MEM_LATENCY+2; ready only in IDLE; responses are never backpressured.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int LSU_PRIORITY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              owner;
    logic              last_lsu;
    logic              grant_ifu, grant_lsu;
    logic [DATA_W-1:0] ifu_data, lsu_data;
    logic [DATA_W-1:0] rd_masked;

    always_comb begin
        state_nxt = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        case (state)
            IDLE: begin
                // reset gates ready so nothing is offered while the block is held in reset
                if (reset) begin
                    if (ifu_req_valid && lsu_req_valid) begin
                        if (LSU_PRIORITY != 0 || !last_lsu) grant_lsu = 1'b1;
                        else                                grant_ifu = 1'b1;
                    end else begin
                        grant_ifu = ifu_req_valid;
                        grant_lsu = lsu_req_valid;
                    end
                end
                if (grant_ifu || grant_lsu) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt <= 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_masked = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (mem_wmask[i]) rd_masked[8*i +: 8] = mem_rdata[8*i +: 8];
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_valid      = (state == ISSUE);
    assign ifu_resp_valid = (state == RESP) && !owner;
    assign lsu_resp_valid = (state == RESP) && owner;
    assign ifu_resp_data  = ifu_data;
    assign lsu_resp_data  = lsu_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner     <= 1'b0;
            last_lsu  <= 1'b1;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            ifu_data  <= '0;
            lsu_data  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ifu) begin
                mem_addr  <= ifu_req_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '1;
                owner     <= 1'b0;
                last_lsu  <= 1'b0;
            end
            if (grant_lsu) begin
                mem_addr  <= lsu_req_addr;
                mem_wen   <= lsu_req_wen;
                mem_wdata <= lsu_req_wdata;
                mem_wmask <= lsu_req_wmask;
                owner     <= 1'b1;
                last_lsu  <= 1'b1;
            end
            if (state == ISSUE) cnt <= 4'(MEM_LATENCY);
            if (state == WAIT) begin
                if (cnt > 4'd1) cnt <= cnt - 4'd1;
                else if (owner) lsu_data <= mem_wen ? '0 : rd_masked;
                else            ifu_data <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (latency 1/4/15, both arbitration modes),
// directed test-plan requests followed by random traffic; one instance also takes a mid-WAIT reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit done [3];

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } strobe_t;

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } resp_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_2000) return 32'hAABB_CCDD;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L   = (g == 0) ? 1 : ((g == 1) ? 4 : 15);
        localparam int PRI = (g == 1) ? 0 : 1;

        logic        rst_n;
        logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
        logic [31:0] ifu_req_addr, ifu_resp_data;
        logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
        logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
        logic [3:0]  lsu_req_wmask;
        logic        mem_valid, mem_wen;
        logic [31:0] mem_addr, mem_wdata;
        logic [31:0] mem_rdata = 32'h0;
        logic [3:0]  mem_wmask;

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .LSU_PRIORITY(PRI)) dut (
            .clock(clk), .reset(rst_n),
            .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
            .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
            .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
            .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
            .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
            .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
            .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
        );

        int cyc = 0;
        always @(negedge clk) cyc <= cyc + 1;

        strobe_t sq[$];
        resp_t   rq[$];

        task automatic chk_all_zero(input string tag);
            chk($sformatf("u%0d %s ifu_ready", g, tag), ifu_req_ready, 0);
            chk($sformatf("u%0d %s lsu_ready", g, tag), lsu_req_ready, 0);
            chk($sformatf("u%0d %s resp_valids", g, tag), {ifu_resp_valid, lsu_resp_valid}, 0);
            chk($sformatf("u%0d %s resp_data", g, tag), {ifu_resp_data, lsu_resp_data}, 0);
            chk($sformatf("u%0d %s mem_valid", g, tag), mem_valid, 0);
            chk($sformatf("u%0d %s mem_addr", g, tag), mem_addr, 0);
            chk($sformatf("u%0d %s mem_wen", g, tag), mem_wen, 0);
            chk($sformatf("u%0d %s mem_wdata", g, tag), mem_wdata, 0);
            chk($sformatf("u%0d %s mem_wmask", g, tag), mem_wmask, 0);
        endtask

        // stimulus + arbitration/readiness reference model
        initial begin
            int          next_ok, dir, rst_cnt, last_hs;
            bit          rst_done, post_rst;
            logic        last_lsu, iv, lv, we, eg_i, eg_l, own;
            logic [31:0] ia, la, wd, rd;
            logic [3:0]  wm;
            logic        glog[$];
            strobe_t     s;
            resp_t       r;

            rst_n = 1'b0;
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            ifu_req_addr = '0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
            lsu_req_wdata = '0; lsu_req_wmask = '0;
            #3;
            chk_all_zero("reset");
            @(negedge clk);
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            rst_n = 1'b1;
            next_ok = 0; last_lsu = 1'b1; dir = 0; rst_cnt = 0; last_hs = -100;
            rst_done = 0; post_rst = 0;

            for (int it = 0; it < 260; it++) begin
                @(negedge clk);
                if (dir < 6) begin
                    iv = (dir == 0) || (dir >= 3);
                    lv = (dir >= 1);
                    ia = (dir >= 3) ? 32'h8000_0100 : 32'h8000_0000;
                    la = (dir == 2) ? 32'h8000_1000 : 32'h8000_2000;
                    we = (dir == 2);
                    wd = (dir == 2) ? 32'h1234_5678 : 32'hDEAD_BEEF;
                    wm = (dir == 1) ? 4'b0010 : 4'hF;
                end else begin
                    iv = 1'($urandom_range(0, 1));
                    lv = 1'($urandom_range(0, 1));
                    ia = $urandom & 32'hFFFF_FFFC;
                    la = $urandom;
                    we = 1'($urandom_range(0, 1));
                    wd = $urandom;
                    wm = 4'($urandom_range(0, 15));
                end
                if (rst_cnt > 0) begin
                    rst_cnt--;
                    if (rst_cnt == 0) begin
                        iv = 1'b1; lv = 1'b0; post_rst = 1;
                        rst_n = 1'b1;
                    end
                end
                ifu_req_valid = iv; ifu_req_addr = ia;
                lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = we;
                lsu_req_wdata = wd; lsu_req_wmask = wm;
                #1;
                if (post_rst) next_ok = cyc;
                eg_i = 1'b0; eg_l = 1'b0;
                if (rst_n && cyc >= next_ok) begin
                    if (iv && lv) begin
                        if (PRI != 0 || !last_lsu) eg_l = 1'b1;
                        else                      eg_i = 1'b1;
                    end else begin
                        eg_i = iv; eg_l = lv;
                    end
                end
                chk($sformatf("u%0d ifu_ready c%0d", g, cyc), ifu_req_ready, eg_i);
                chk($sformatf("u%0d lsu_ready c%0d", g, cyc), lsu_req_ready, eg_l);
                if (post_rst) begin
                    chk($sformatf("u%0d accept after reset", g), ifu_req_ready, 1);
                    post_rst = 0;
                end
                if (eg_i || eg_l) begin
                    own = eg_l;
                    s.due = cyc + 1; s.owner = own; s.addr = own ? la : ia;
                    s.wen = own ? we : 1'b0; s.wdata = wd; s.wmask = own ? wm : 4'hF;
                    sq.push_back(s);
                    if (!own)    rd = mem_fn(ia);
                    else if (we) rd = 32'h0;
                    else         rd = mem_fn(la) & expand(wm);
                    r.due = cyc + 2 + L; r.owner = own; r.data = rd;
                    rq.push_back(r);
                    next_ok = cyc + 3 + L;
                    last_lsu = own;
                    last_hs = cyc;
                    if (dir >= 3 && dir < 6) glog.push_back(own);
                    if (dir < 6) dir++;
                end
                if (L == 4 && !rst_done && it >= 150 && cyc == last_hs + 3) begin
                    #1;
                    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("mid-wait reset");
                    sq.delete(); rq.delete();
                    rst_cnt = 2; rst_done = 1;
                end
            end

            chk($sformatf("u%0d tie grant count", g), glog.size(), 3);
            for (int k = 0; k < glog.size() && k < 3; k++)
                chk($sformatf("u%0d tie grant %0d owner", g, k), glog[k], (PRI != 0) ? 1'b1 : 1'(k % 2));
            if (L == 4) chk($sformatf("u%0d mid-wait reset exercised", g), rst_done, 1);

            @(negedge clk);
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            repeat (L + 5) @(negedge clk);
            #2;
            chk($sformatf("u%0d scoreboard drained", g), sq.size() + rq.size(), 0);
            done[g] = 1'b1;
        end

        // monitor + memory model
        initial begin
            int          samp_at;
            logic [31:0] samp_addr;
            strobe_t     s;
            resp_t       r;
            samp_at = -1;
            samp_addr = '0;
            forever begin
                @(negedge clk);
                #1;
                if (sq.size() > 0 && sq[0].due == cyc) begin
                    s = sq.pop_front();
                    chk($sformatf("u%0d mem_valid c%0d", g, cyc), mem_valid, 1);
                    chk($sformatf("u%0d mem_addr c%0d", g, cyc), mem_addr, s.addr);
                    chk($sformatf("u%0d mem_wen c%0d", g, cyc), mem_wen, s.wen);
                    chk($sformatf("u%0d mem_wmask c%0d", g, cyc), mem_wmask, s.wmask);
                    if (s.owner) chk($sformatf("u%0d mem_wdata c%0d", g, cyc), mem_wdata, s.wdata);
                    samp_at = cyc + L;
                    samp_addr = mem_addr;
                end else begin
                    chk($sformatf("u%0d idle mem_valid c%0d", g, cyc), mem_valid, 0);
                end
                mem_rdata = (cyc == samp_at) ? mem_fn(samp_addr) : $urandom;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    chk($sformatf("u%0d resp valids c%0d", g, cyc),
                        {ifu_resp_valid, lsu_resp_valid}, {!r.owner, r.owner});
                    chk($sformatf("u%0d resp data c%0d", g, cyc),
                        r.owner ? lsu_resp_data : ifu_resp_data, r.data);
                end else begin
                    chk($sformatf("u%0d idle resp c%0d", g, cyc), {ifu_resp_valid, lsu_resp_valid}, 0);
                end
            end
        end
    end

    initial begin
        bit all_done;
        all_done = 0;
        for (int i = 0; i < 20000 && !all_done; i++) begin
            @(posedge clk);
            all_done = done[0] && done[1] && done[2];
        end
        if (!all_done) begin
            n_chk++;
            $display("FAIL timeout: done flags %0d%0d%0d, expected 111", done[0], done[1], done[2]);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data/instruction memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core. It accepts one request at a time via valid/ready handshakes, registers it, and issues it to memory as a one-cycle strobe. It waits a fixed memory latency, then returns the read data (or a write acknowledge) to the requester that issued it. It sits between the IFU/LSU and the DPI-backed memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask width is DATA_W/8
- MEM_LATENCY, 1, cycles from the mem_valid cycle to the mem_rdata sample cycle; legal values are 1..15
- LSU_PRIORITY, 1, 1 = LSU wins ties; 0 = round-robin
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address (the pc)
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_resp_data  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  access address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  DATA_W/8  byte-lane mask, used for both reads and writes
- lsu_resp_valid  out  1  one-cycle pulse, access complete
- lsu_resp_data  out  DATA_W  masked read data; 0 for writes
- mem_valid  out  1  one-cycle memory access strobe
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  DATA_W/8  registered mask; all ones for IFU reads
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ready goes to at most one requester, combinationally from the valids.
  - On a handshake, latch addr/wen/wdata/wmask and the owner bit (0 = IFU, 1 = LSU), then go to ISSUE.
  - An IFU request latches wen=0 and wmask=all ones.
- ISSUE: mem_valid=1 for exactly one cycle, counter loaded with MEM_LATENCY, go to WAIT.
- WAIT:
  - Counter decrements every cycle.
  - On the cycle the counter reaches 1, sample mem_rdata into the data register and go to RESP.
- RESP:
  - Assert the owner's resp_valid for one cycle with the registered data, then go to IDLE.
  - Never assert both resp_valids.
- Arbitration:
  - LSU_PRIORITY=1: the LSU wins whenever lsu_req_valid=1.
  - LSU_PRIORITY=0: on a tie, grant the requester not granted last. The last-grant pointer resets to LSU, so the IFU wins the first tie.
  - The pointer updates only on a handshake.
- LSU read data: byte lane i = mem_rdata lane i if wmask[i], else 0.
- LSU writes: lsu_resp_data=0; the resp pulse is the completion acknowledge.
- ready is 0 in every state except IDLE. Requesters may drop valid before ready without effect.
- Request inputs are sampled only on the handshake cycle.
- No backpressure on responses; requesters must accept the pulse.
- Counter width is 4 bits, with no wrap: it loads in ISSUE and stops at 1.

## Timing
- Reset asserted (reset=0):
  - Immediately forces IDLE.
  - All outputs are 0: ready, resp_valid, resp_data, mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask.
  - The in-flight transaction is discarded and no response is ever produced for it.
  - Pointer set to LSU.
- After reset deasserts, a request may be accepted on the first rising edge.
- Latency, with handshake at cycle T:
  - mem_valid at T+1.
  - mem_rdata sampled at T+1+MEM_LATENCY.
  - resp_valid at T+2+MEM_LATENCY.
  - Next possible handshake at T+3+MEM_LATENCY.
- Throughput: one transaction per MEM_LATENCY+3 cycles.
- mem_addr/wen/wdata/wmask hold their registered values from ISSUE until the next handshake.
- resp_data holds until the next RESP.

## Test plan
- Single IFU fetch, MEM_LATENCY=1:
  - Stimulus: addr 0x80000000, memory returns 0x00000413.
  - Required: ifu_req_ready at T, mem_valid at T+1 with mem_wmask=0xF, ifu_resp_valid at T+3 with 0x00000413, lsu_resp_valid stays 0.
- LSU byte read:
  - Stimulus: wmask=0b0010, memory returns 0xAABBCCDD.
  - Required: lsu_resp_data=0x0000CC00.
- LSU write:
  - Stimulus: addr 0x80001000, wdata 0x12345678, wmask 0xF.
  - Required: one mem_valid cycle with mem_wen=1 and those values, lsu_resp_valid pulse with data 0.
- Simultaneous valids, held continuously:
  - LSU_PRIORITY=1: three consecutive grants all go to the LSU.
  - LSU_PRIORITY=0: grants alternate IFU, LSU, IFU.
  - Grants are spaced MEM_LATENCY+3 cycles apart.
- Reset mid-transaction:
  - Stimulus: drive reset=0 during WAIT (MEM_LATENCY=4), asynchronously between edges.
  - Required: all outputs 0 before the next edge, no resp_valid afterwards, and a new IFU request accepted on the first edge after release.
- MEM_LATENCY=15: resp_valid arrives exactly 17 cycles after the handshake, and the counter shows no wrap.
